// File: rtl/vm_decode_scan_pkg.sv
// Shared definitions for the vm_decode_scan select decoder / scanner.
// Holds the mode encoding and the prescaler width helper.
package vm_decode_scan_pkg;

    // Mode register encoding; also the meaning of the modo input.
    typedef enum logic {
        VM_MODO_DIRECT = 1'b0,
        VM_MODO_SCAN   = 1'b1
    } vm_modo_e;

    // Prescaler width for a slot of div cycles; never narrower than 1 bit
    // so DIV=1 still yields a legal (constant-zero) register.
    function automatic int vm_pre_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/vm_onehot.sv
// Combinational SEL_W -> 2**SEL_W one-hot decoder with enable.
// Active-high only; any output polarity inversion belongs to the parent.
module vm_onehot #(
    parameter int SEL_W = 2
) (
    input  logic                    en,
    input  logic [SEL_W-1:0]        sel,
    output logic [(2**SEL_W)-1:0]   y
);

    // Single line high at position sel, or all low when disabled.
    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/vm_decode_scan.sv
// Registered one-hot select driver: direct decode of sel, or auto-scan
// stepping through all outputs every DIV cycles (digit strobing).
// Optional macro VM_DEC_BLANK_EN: blanks S for the first BLANK cycles of
// every scan slot (anti-ghosting); idx/wrap timing is not affected.
//
// Mode register states:
//   state          | meaning
//   VM_MODO_DIRECT | idx follows sel each enabled cycle, prescaler held at 0
//   VM_MODO_SCAN   | prescaler counts 0..DIV-1, idx advances at DIV-1
module vm_decode_scan
    import vm_decode_scan_pkg::*;
#(
    parameter int SEL_W   = 2,
    parameter int DIV     = 4,
    parameter int BLANK   = 1,
    parameter int ACT_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    modo,
    input  logic [SEL_W-1:0]        sel,
    output logic [(2**SEL_W)-1:0]   S,
    output logic [SEL_W-1:0]        idx,
    output logic                    wrap
);

    localparam int N_OUT = 2**SEL_W;
    localparam int PW    = vm_pre_w(DIV);

    localparam logic [PW-1:0]    PRE_LAST  = PW'(DIV - 1);
    localparam logic [PW-1:0]    PRE_BLANK = PW'(BLANK);
    localparam logic [SEL_W-1:0] IDX_LAST  = SEL_W'(N_OUT - 1);
    localparam logic [N_OUT-1:0] S_IDLE    = (ACT_LOW != 0) ? '1 : '0;

`ifdef VM_DEC_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    vm_modo_e           mode_q, mode_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [PW-1:0]      pre_q, pre_d;
    logic               wrap_q, wrap_d;
    logic [N_OUT-1:0]   s_q, s_d;
    logic               dec_en;
    logic [N_OUT-1:0]   dec;

    // Next-state: direct follow, scan entry, scan step, or freeze when en=0.
    always_comb begin
        mode_d = mode_q;
        idx_d  = idx_q;
        pre_d  = pre_q;
        wrap_d = 1'b0;
        dec_en = 1'b0;
        if (en) begin
            dec_en = 1'b1;
            if (modo == VM_MODO_DIRECT) begin
                mode_d = VM_MODO_DIRECT;
                idx_d  = sel;
                pre_d  = '0;
            end else if (mode_q == VM_MODO_DIRECT) begin
                mode_d = VM_MODO_SCAN;
                idx_d  = sel;
                pre_d  = '0;
            end else if (pre_q == PRE_LAST) begin
                pre_d  = '0;
                idx_d  = idx_q + 1'b1;
                wrap_d = (idx_q == IDX_LAST);
            end else begin
                pre_d  = pre_q + 1'b1;
            end
            // Dead time at the head of each scan slot, keyed off the
            // prescaler so no separate counter is needed.
            if (BLANK_ON && (mode_d == VM_MODO_SCAN) && (pre_d < PRE_BLANK)) begin
                dec_en = 1'b0;
            end
        end
    end

    vm_onehot #(
        .SEL_W (SEL_W)
    ) u_onehot (
        .en  (dec_en),
        .sel (idx_d),
        .y   (dec)
    );

    // Output polarity is applied before the register so S is glitch-free.
    always_comb begin
        s_d = (ACT_LOW != 0) ? ~dec : dec;
    end

    // State and output registers; async reset returns everything to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= VM_MODO_DIRECT;
            idx_q  <= '0;
            pre_q  <= '0;
            wrap_q <= 1'b0;
            s_q    <= S_IDLE;
        end else begin
            mode_q <= mode_d;
            idx_q  <= idx_d;
            pre_q  <= pre_d;
            wrap_q <= wrap_d;
            s_q    <= s_d;
        end
    end

    assign S    = s_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_vm_decode_scan.sv
// Bench for vm_decode_scan: two instances share stimulus, one with DIV=4
// active-high (BLANK=1), one with DIV=1 active-low. A slot-countdown model
// produces expectations into a scoreboard queue at each rising edge; they
// are popped and compared on the falling edge. Directed literal checks
// cover the documented scenarios.
`timescale 1ns/1ps
module tb_vm_decode_scan;

    localparam int DIV_A   = 4;
    localparam int BLANK_A = 1;
    localparam int DIV_B   = 1;

`ifdef VM_DEC_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       modo;
    logic [1:0] sel;
    logic [3:0] s_a, s_b;
    logic [1:0] idx_a, idx_b;
    logic       wrap_a, wrap_b;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    vm_decode_scan #(
        .SEL_W (2), .DIV (DIV_A), .BLANK (BLANK_A), .ACT_LOW (0)
    ) u_a (
        .clk (clk), .rst_n (rst_n), .en (en), .modo (modo), .sel (sel),
        .S (s_a), .idx (idx_a), .wrap (wrap_a)
    );

    vm_decode_scan #(
        .SEL_W (2), .DIV (DIV_B), .BLANK (0), .ACT_LOW (1)
    ) u_b (
        .clk (clk), .rst_n (rst_n), .en (en), .modo (modo), .sel (sel),
        .S (s_b), .idx (idx_b), .wrap (wrap_b)
    );

    // Model state: left = cycles still to show in the current slot after this one.
    typedef struct packed {
        logic [1:0]  idx;
        logic [15:0] left;
        logic        scan;
        logic [3:0]  s;
        logic        wrap;
    } mst_t;

    typedef struct packed {
        logic [3:0] sa;
        logic [1:0] ia;
        logic       wa;
        logic [3:0] sb;
        logic [1:0] ib;
        logic       wb;
    } exp_t;

    mst_t ma, mb;
    exp_t sb_q[$];

    function automatic mst_t mreset();
        mst_t r;
        r = '0;
        return r;
    endfunction

    function automatic mst_t mnext(input mst_t m, input int div, input int blank,
                                   input logic en_i, input logic modo_i,
                                   input logic [1:0] sel_i);
        mst_t r;
        r = m;
        r.wrap = 1'b0;
        if (!en_i) begin
            r.s = 4'b0000;
            return r;
        end
        if (!modo_i) begin
            r.scan = 1'b0;
            r.idx  = sel_i;
            r.left = 16'(div - 1);
            r.s    = 4'b0001 << sel_i;
            return r;
        end
        if (!m.scan) begin
            r.scan = 1'b1;
            r.idx  = sel_i;
            r.left = 16'(div - 1);
        end else if (m.left == 0) begin
            r.wrap = (m.idx == 2'd3);
            r.idx  = m.idx + 2'd1;
            r.left = 16'(div - 1);
        end else begin
            r.left = m.left - 16'd1;
        end
        r.s = 4'b0001 << r.idx;
        if (BLANK_ON && ((div - 1 - int'(r.left)) < blank)) r.s = 4'b0000;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: model update and push at the rising edge, pop and compare at the falling edge.
    task automatic step();
        exp_t e, g;
        @(posedge clk);
        if (!rst_n) begin
            ma = mreset();
            mb = mreset();
        end else begin
            ma = mnext(ma, DIV_A, BLANK_A, en, modo, sel);
            mb = mnext(mb, DIV_B, 0, en, modo, sel);
        end
        e.sa = ma.s;  e.ia = ma.idx; e.wa = ma.wrap;
        e.sb = ~mb.s; e.ib = mb.idx; e.wb = mb.wrap;
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            g = sb_q.pop_front();
            chk("sb_s_a", 32'(s_a), 32'(g.sa));
            chk("sb_idx_a", 32'(idx_a), 32'(g.ia));
            chk("sb_wrap_a", 32'(wrap_a), 32'(g.wa));
            chk("sb_s_b", 32'(s_b), 32'(g.sb));
            chk("sb_idx_b", 32'(idx_b), 32'(g.ib));
            chk("sb_wrap_b", 32'(wrap_b), 32'(g.wb));
        end
    endtask

    initial begin
        logic [3:0] exp_b [5];
        exp_b = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        rst_n = 1'b0; en = 1'b0; modo = 1'b0; sel = 2'd0;
        ma = mreset(); mb = mreset();
        repeat (2) step();
        chk("rst_s_a", 32'(s_a), 32'h0);
        chk("rst_idx_a", 32'(idx_a), 32'h0);
        chk("rst_wrap_a", 32'(wrap_a), 32'h0);
        chk("rst_s_b", 32'(s_b), 32'hF);

        // direct decode
        rst_n = 1'b1; en = 1'b1; sel = 2'd2;
        step();
        chk("dir_s2", 32'(s_a), 32'b0100);
        chk("dir_idx2", 32'(idx_a), 32'd2);
        sel = 2'd3;
        step();
        chk("dir_s3", 32'(s_a), 32'b1000);

        // scan from sel=1, wraps at steps 13 and 29
        modo = 1'b1; sel = 2'd1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (i == 1) chk("scan_entry_idx", 32'(idx_a), 32'd1);
            if (i == 13 || i == 29) chk("scan_wrap", 32'(wrap_a), 32'd1);
        end
        sel = 2'd0;
        repeat (12) step();
        chk("pre_freeze_idx", 32'(idx_a), 32'd3);

        // freeze mid-slot, then resume
        en = 1'b0;
        repeat (5) begin
            step();
            chk("frz_s", 32'(s_a), 32'h0);
            chk("frz_idx", 32'(idx_a), 32'd3);
        end
        en = 1'b1;
        repeat (2) begin
            step();
            chk("resume_s", 32'(s_a), 32'b1000);
        end
        step();
        chk("resume_wrap", 32'(wrap_a), 32'd1);
        chk("resume_idx", 32'(idx_a), 32'd0);

        // run on to idx 2 then leave scan
        repeat (8) step();
        chk("pre_exit_idx", 32'(idx_a), 32'd2);
        modo = 1'b0; sel = 2'd0;
        step();
        chk("exit_s", 32'(s_a), 32'b0001);
        chk("exit_wrap", 32'(wrap_a), 32'd0);

        // async reset between edges, mid-slot
        modo = 1'b1; sel = 2'd2;
        repeat (2) step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_s_a", 32'(s_a), 32'h0);
        chk("arst_idx_a", 32'(idx_a), 32'h0);
        chk("arst_wrap_a", 32'(wrap_a), 32'h0);
        chk("arst_s_b", 32'(s_b), 32'hF);
        step();
        rst_n = 1'b1; en = 1'b1; modo = 1'b0; sel = 2'd0;
        step();

        // scan from sel=0: DIV=1 active-low sequence, no wrap on entry
        modo = 1'b1; sel = 2'd0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("al_s_b", 32'(s_b), 32'(exp_b[i]));
            chk("al_wrap_b", 32'(wrap_b), (i == 4) ? 32'd1 : 32'd0);
            if (i == 0) begin
                chk("entry0_wrap_a", 32'(wrap_a), 32'd0);
                chk("entry0_s_a", 32'(s_a), BLANK_ON ? 32'b0000 : 32'b0001);
            end
            if (i == 1) chk("slot0_s_a", 32'(s_a), 32'b0001);
            if (i == 4) chk("slot1_s_a", 32'(s_a), BLANK_ON ? 32'b0000 : 32'b0010);
        end

        // mode change while disabled takes effect when en returns
        en = 1'b0; modo = 1'b0; sel = 2'd3;
        repeat (2) step();
        en = 1'b1;
        step();
        chk("en_dir_s", 32'(s_a), 32'b1000);
        chk("en_dir_idx", 32'(idx_a), 32'd3);
        en = 1'b0; modo = 1'b1; sel = 2'd1;
        repeat (2) step();
        en = 1'b1;
        step();
        chk("en_scan_idx", 32'(idx_a), 32'd1);
        repeat (6) step();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
